// File: rtl/matrix_stack.sv
// Modelview and projection matrix stacks: serves the top-of-stack to the multiplier,
// takes its write-back, and runs push/pop/load-identity/BRAM-load commands.
module matrix_stack #(
    parameter int          MV_DEPTH = 8,
    parameter int          PJ_DEPTH = 2,
    parameter logic [31:0] ONE      = 32'h3F800000,
    localparam int         MV_W     = $clog2(MV_DEPTH),
    localparam int         PJ_W     = $clog2(PJ_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            cmd_valid,
    input  logic [2:0]      cmd_op,
    input  logic            cmd_mode,
    output logic            cmd_ready,
    output logic            busy,

    input  logic            peek_mode,
    output logic [127:0]    matrix_peek_0,
    output logic [127:0]    matrix_peek_1,
    output logic [127:0]    matrix_peek_2,
    output logic [127:0]    matrix_peek_3,

    input  logic            matrix_mode_in,
    input  logic            matrix_write_en,
    input  logic [127:0]    matrix_write_in_0,
    input  logic [127:0]    matrix_write_in_1,
    input  logic [127:0]    matrix_write_in_2,
    input  logic [127:0]    matrix_write_in_3,

    input  logic [31:0]     bram_addr_in,
    output logic [31:0]     bram_addr_out,
    input  logic [31:0]     bram_read_in_0,
    input  logic [31:0]     bram_read_in_1,
    input  logic [31:0]     bram_read_in_2,
    input  logic [31:0]     bram_read_in_3,

    output logic [MV_W-1:0] mv_level,
    output logic [PJ_W-1:0] pj_level,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_LOAD_ID = 3'd3;
    localparam logic [2:0] OP_LOAD_BR = 3'd4;
    localparam logic [2:0] OP_CLR_ERR = 3'd5;

    localparam logic [511:0] IDENTITY = {ONE, 96'd0, 32'd0, ONE, 64'd0,
                                         64'd0, ONE, 32'd0, 96'd0, ONE};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD0,
        S_LD1,
        S_LD2,
        S_LD3,
        S_LD4
    } state_t;

    state_t          state_q, state_d;
    logic [MV_W-1:0] mv_ptr;
    logic [PJ_W-1:0] pj_ptr;
    logic [383:0]    ld_rows;
    logic            ld_mode;

    logic            cmd_fire, do_push, do_pop, do_ident, do_load, do_clr;
    logic            mv_can_push, mv_can_pop, pj_can_push, pj_can_pop;
    logic            mv_push_ok, pj_push_ok, ident_mv, ident_pj;
    logic            ld_commit;
    logic [511:0]    ld_data, wb_data, mv_top, pj_top, peek_top;
    logic [511:0]    mv_q [MV_DEPTH];
    logic [511:0]    pj_q [PJ_DEPTH];

    // Priority for one entry: BRAM commit > write-back > push copy > load identity.
    // Commands never coincide with a write-back, so only the commit can override it.
    function automatic logic [511:0] next_entry(
        input logic [511:0] cur,
        input logic         commit_hit,
        input logic         wb_hit,
        input logic         push_hit,
        input logic         ident_hit,
        input logic [511:0] commit_data,
        input logic [511:0] wb_row_data,
        input logic [511:0] push_data
    );
        logic [511:0] r;
        r = cur;
        if (commit_hit)     r = commit_data;
        else if (wb_hit)    r = wb_row_data;
        else if (push_hit)  r = push_data;
        else if (ident_hit) r = IDENTITY;
        return r;
    endfunction

    assign busy      = (state_q != S_IDLE);
    assign cmd_ready = !busy && !matrix_write_en;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign do_push   = cmd_fire && (cmd_op == OP_PUSH);
    assign do_pop    = cmd_fire && (cmd_op == OP_POP);
    assign do_ident  = cmd_fire && (cmd_op == OP_LOAD_ID);
    assign do_load   = cmd_fire && (cmd_op == OP_LOAD_BR);
    assign do_clr    = cmd_fire && (cmd_op == OP_CLR_ERR);

    assign mv_can_push = (mv_ptr != MV_W'(MV_DEPTH - 1));
    assign mv_can_pop  = (mv_ptr != '0);
    assign pj_can_push = (pj_ptr != PJ_W'(PJ_DEPTH - 1));
    assign pj_can_pop  = (pj_ptr != '0);
    assign mv_push_ok  = do_push && !cmd_mode && mv_can_push;
    assign pj_push_ok  = do_push && cmd_mode && pj_can_push;
    assign ident_mv    = do_ident && !cmd_mode;
    assign ident_pj    = do_ident && cmd_mode;

    assign ld_commit = (state_q == S_LD4);
    assign ld_data   = {ld_rows, bram_read_in_0, bram_read_in_1, bram_read_in_2, bram_read_in_3};
    assign wb_data   = {matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3};

    for (genvar i = 0; i < MV_DEPTH; i++) begin : g_mv
        logic [511:0] entry, entry_d;
        logic         at_top, at_next;
        assign at_top  = (mv_ptr == MV_W'(i));
        assign at_next = (i != 0) && mv_push_ok && (mv_ptr == MV_W'(i - 1));
        assign entry_d = next_entry(entry, ld_commit && !ld_mode && at_top,
                                    matrix_write_en && !matrix_mode_in && at_top,
                                    at_next, ident_mv && at_top, ld_data, wb_data, mv_top);
        // Only the bottom entry is reset; deeper entries keep whatever they held.
        if (i == 0) begin : g_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) entry <= IDENTITY;
                else     entry <= entry_d;
            end
        end else begin : g_norst
            always_ff @(posedge clk) entry <= entry_d;
        end
        assign mv_q[i] = entry;
    end

    for (genvar i = 0; i < PJ_DEPTH; i++) begin : g_pj
        logic [511:0] entry, entry_d;
        logic         at_top, at_next;
        assign at_top  = (pj_ptr == PJ_W'(i));
        assign at_next = (i != 0) && pj_push_ok && (pj_ptr == PJ_W'(i - 1));
        assign entry_d = next_entry(entry, ld_commit && ld_mode && at_top,
                                    matrix_write_en && matrix_mode_in && at_top,
                                    at_next, ident_pj && at_top, ld_data, wb_data, pj_top);
        if (i == 0) begin : g_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) entry <= IDENTITY;
                else     entry <= entry_d;
            end
        end else begin : g_norst
            always_ff @(posedge clk) entry <= entry_d;
        end
        assign pj_q[i] = entry;
    end

    assign mv_top   = mv_q[mv_ptr];
    assign pj_top   = pj_q[pj_ptr];
    assign peek_top = peek_mode ? pj_top : mv_top;

    assign matrix_peek_0 = peek_top[511:384];
    assign matrix_peek_1 = peek_top[383:256];
    assign matrix_peek_2 = peek_top[255:128];
    assign matrix_peek_3 = peek_top[127:0];

    assign mv_level = mv_ptr;
    assign pj_level = pj_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_ptr    <= '0;
            pj_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                if (!cmd_mode) begin
                    if (mv_can_push) mv_ptr <= mv_ptr + 1'b1;
                    else             overflow <= 1'b1;
                end else begin
                    if (pj_can_push) pj_ptr <= pj_ptr + 1'b1;
                    else             overflow <= 1'b1;
                end
            end
            if (do_pop) begin
                if (!cmd_mode) begin
                    if (mv_can_pop) mv_ptr <= mv_ptr - 1'b1;
                    else            underflow <= 1'b1;
                end else begin
                    if (pj_can_pop) pj_ptr <= pj_ptr - 1'b1;
                    else            underflow <= 1'b1;
                end
            end
            if (do_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (do_load) state_d = S_LD0;
            S_LD0:   state_d = S_LD1;
            S_LD1:   state_d = S_LD2;
            S_LD2:   state_d = S_LD3;
            S_LD3:   state_d = S_LD4;
            S_LD4:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address leads data by one cycle: LDk presents base+4k, LD(k+1) captures row k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr_out <= '0;
            ld_rows       <= '0;
            ld_mode       <= 1'b0;
        end else begin
            if (do_load) begin
                bram_addr_out <= bram_addr_in;
                ld_mode       <= cmd_mode;
            end else if (state_q == S_LD0 || state_q == S_LD1 || state_q == S_LD2) begin
                bram_addr_out <= bram_addr_out + 32'd4;
            end
            case (state_q)
                S_LD1:   ld_rows[383:256] <= {bram_read_in_0, bram_read_in_1, bram_read_in_2, bram_read_in_3};
                S_LD2:   ld_rows[255:128] <= {bram_read_in_0, bram_read_in_1, bram_read_in_2, bram_read_in_3};
                S_LD3:   ld_rows[127:0]   <= {bram_read_in_0, bram_read_in_1, bram_read_in_2, bram_read_in_3};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stack.sv
// Directed self-checking bench for matrix_stack: reset, write/push/pop, saturation,
// BRAM load timing, write-back arbitration and reset during a load.
module tb_matrix_stack;

    localparam logic [31:0]  ONE   = 32'h3F800000;
    localparam logic [511:0] IDENT = {ONE, 96'd0, 32'd0, ONE, 64'd0, 64'd0, ONE, 32'd0, 96'd0, ONE};
    localparam logic [511:0] R1    = {128'h1, 128'h2, 128'h3, 128'h4};
    localparam logic [511:0] R2    = {128'h5, 128'h6, 128'h7, 128'h8};
    localparam logic [511:0] R3    = {128'h9, 128'hA, 128'hB, 128'hC};
    localparam logic [511:0] RA    = {128'hAAAA_0001, 128'hAAAA_0002, 128'hAAAA_0003, 128'hAAAA_0004};
    localparam logic [511:0] LDX   = {{4{32'h100}}, {4{32'h104}}, {4{32'h108}}, {4{32'h10C}}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_op = 3'd0;
    logic          cmd_mode = 1'b0;
    logic          cmd_ready, busy;
    logic          peek_mode = 1'b0;
    logic [127:0]  matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3;
    logic          matrix_mode_in = 1'b0;
    logic          matrix_write_en = 1'b0;
    logic [127:0]  matrix_write_in_0 = '0, matrix_write_in_1 = '0;
    logic [127:0]  matrix_write_in_2 = '0, matrix_write_in_3 = '0;
    logic [31:0]   bram_addr_in = '0;
    logic [31:0]   bram_addr_out;
    logic [31:0]   bram_read_in_0 = '0, bram_read_in_1 = '0, bram_read_in_2 = '0, bram_read_in_3 = '0;
    logic [2:0]    mv_level;
    logic [0:0]    pj_level;
    logic          overflow, underflow;
    logic [511:0]  peek_all;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_stack dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
        .cmd_ready(cmd_ready), .busy(busy),
        .peek_mode(peek_mode),
        .matrix_peek_0(matrix_peek_0), .matrix_peek_1(matrix_peek_1),
        .matrix_peek_2(matrix_peek_2), .matrix_peek_3(matrix_peek_3),
        .matrix_mode_in(matrix_mode_in), .matrix_write_en(matrix_write_en),
        .matrix_write_in_0(matrix_write_in_0), .matrix_write_in_1(matrix_write_in_1),
        .matrix_write_in_2(matrix_write_in_2), .matrix_write_in_3(matrix_write_in_3),
        .bram_addr_in(bram_addr_in), .bram_addr_out(bram_addr_out),
        .bram_read_in_0(bram_read_in_0), .bram_read_in_1(bram_read_in_1),
        .bram_read_in_2(bram_read_in_2), .bram_read_in_3(bram_read_in_3),
        .mv_level(mv_level), .pj_level(pj_level),
        .overflow(overflow), .underflow(underflow)
    );

    assign peek_all = {matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3};

    // BRAM model: every lane returns the address, one cycle after it is presented.
    always @(posedge clk) begin
        bram_read_in_0 <= bram_addr_out;
        bram_read_in_1 <= bram_addr_out;
        bram_read_in_2 <= bram_addr_out;
        bram_read_in_3 <= bram_addr_out;
    end

    task automatic do_cmd(input logic [2:0] op, input logic mode);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_mode = mode;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
    endtask

    task automatic set_write(input logic mode, input logic [511:0] rows);
        matrix_write_en   = 1'b1;
        matrix_mode_in    = mode;
        matrix_write_in_0 = rows[511:384];
        matrix_write_in_1 = rows[383:256];
        matrix_write_in_2 = rows[255:128];
        matrix_write_in_3 = rows[127:0];
    endtask

    task automatic do_write(input logic mode, input logic [511:0] rows);
        @(negedge clk);
        set_write(mode, rows);
        @(negedge clk);
        matrix_write_en = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        peek_mode = 1'b0; #1;
        checks++; if (matrix_peek_0 !== {ONE, 96'd0}) begin errors++; $display("FAIL reset_mv_row0 got %h exp %h", matrix_peek_0, {ONE, 96'd0}); end
        checks++; if (matrix_peek_3 !== {96'd0, ONE}) begin errors++; $display("FAIL reset_mv_row3 got %h exp %h", matrix_peek_3, {96'd0, ONE}); end
        checks++; if (peek_all !== IDENT) begin errors++; $display("FAIL reset_mv_ident got %h exp %h", peek_all, IDENT); end
        peek_mode = 1'b1; #1;
        checks++; if (peek_all !== IDENT) begin errors++; $display("FAIL reset_pj_ident got %h exp %h", peek_all, IDENT); end
        checks++; if ({mv_level, pj_level} !== 4'd0) begin errors++; $display("FAIL reset_levels got %h exp 0", {mv_level, pj_level}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); end
        checks++; if ({busy, cmd_ready} !== 2'b01) begin errors++; $display("FAIL reset_busy_ready got %b exp 01", {busy, cmd_ready}); end
        checks++; if (bram_addr_out !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", bram_addr_out); end
    endtask

    task automatic test_write_push_pop;
        peek_mode = 1'b0;
        do_write(1'b0, R1);
        checks++; if (peek_all !== R1) begin errors++; $display("FAIL wpp_write got %h exp %h", peek_all, R1); end
        do_cmd(3'd1, 1'b0);
        checks++; if (mv_level !== 3'd1) begin errors++; $display("FAIL wpp_push_level got %0d exp 1", mv_level); end
        checks++; if (peek_all !== R1) begin errors++; $display("FAIL wpp_push_dup got %h exp %h", peek_all, R1); end
        do_write(1'b0, R2);
        checks++; if (peek_all !== R2) begin errors++; $display("FAIL wpp_write2 got %h exp %h", peek_all, R2); end
        do_cmd(3'd2, 1'b0);
        checks++; if (mv_level !== 3'd0) begin errors++; $display("FAIL wpp_pop_level got %0d exp 0", mv_level); end
        checks++; if (peek_all !== R1) begin errors++; $display("FAIL wpp_pop_top got %h exp %h", peek_all, R1); end
        peek_mode = 1'b1; #1;
        checks++; if (peek_all !== IDENT) begin errors++; $display("FAIL wpp_pj_untouched got %h exp %h", peek_all, IDENT); end
        peek_mode = 1'b0;
    endtask

    task automatic test_mv_saturation;
        peek_mode = 1'b0;
        for (int i = 0; i < 7; i++) do_cmd(3'd1, 1'b0);
        checks++; if ({mv_level, overflow} !== {3'd7, 1'b0}) begin errors++; $display("FAIL mv_full got lvl %0d ovf %b exp 7 0", mv_level, overflow); end
        do_cmd(3'd1, 1'b0);
        checks++; if ({mv_level, overflow} !== {3'd7, 1'b1}) begin errors++; $display("FAIL mv_overflow got lvl %0d ovf %b exp 7 1", mv_level, overflow); end
        checks++; if (peek_all !== R1) begin errors++; $display("FAIL mv_top_dup got %h exp %h", peek_all, R1); end
        for (int i = 0; i < 7; i++) do_cmd(3'd2, 1'b0);
        checks++; if ({mv_level, underflow} !== {3'd0, 1'b0}) begin errors++; $display("FAIL mv_empty got lvl %0d unf %b exp 0 0", mv_level, underflow); end
        do_cmd(3'd5, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mv_clr got %b exp 0", overflow); end
        do_cmd(3'd3, 1'b0);
        checks++; if (peek_all !== IDENT) begin errors++; $display("FAIL mv_load_ident got %h exp %h", peek_all, IDENT); end
    endtask

    task automatic test_pj_saturation;
        do_write(1'b1, R2);
        peek_mode = 1'b1; #1;
        checks++; if (peek_all !== R2) begin errors++; $display("FAIL pj_write got %h exp %h", peek_all, R2); end
        do_cmd(3'd1, 1'b1);
        checks++; if ({pj_level, overflow} !== 2'b10) begin errors++; $display("FAIL pj_push1 got lvl %0d ovf %b exp 1 0", pj_level, overflow); end
        do_cmd(3'd1, 1'b1);
        checks++; if ({pj_level, overflow} !== 2'b11) begin errors++; $display("FAIL pj_overflow got lvl %0d ovf %b exp 1 1", pj_level, overflow); end
        checks++; if (peek_all !== R2) begin errors++; $display("FAIL pj_top_dup got %h exp %h", peek_all, R2); end
        do_cmd(3'd2, 1'b1);
        do_cmd(3'd2, 1'b1);
        checks++; if ({pj_level, underflow} !== 2'b01) begin errors++; $display("FAIL pj_underflow got lvl %0d unf %b exp 0 1", pj_level, underflow); end
        checks++; if (mv_level !== 3'd0) begin errors++; $display("FAIL pj_mv_untouched got %0d exp 0", mv_level); end
        do_cmd(3'd5, 1'b1);
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL pj_clr got %b exp 00", {overflow, underflow}); end
        peek_mode = 1'b0;
    endtask

    task automatic test_load_bram;
        peek_mode = 1'b0;
        @(negedge clk);
        bram_addr_in = 32'h100; cmd_valid = 1'b1; cmd_op = 3'd4; cmd_mode = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
        checks++; if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL ld0_busy_ready got %b exp 10", {busy, cmd_ready}); end
        checks++; if (bram_addr_out !== 32'h100) begin errors++; $display("FAIL ld0_addr got %h exp 100", bram_addr_out); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) matrix_write_en = 1'b0;
            checks++; if (bram_addr_out !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL ld%0d_addr got %h exp %h", k, bram_addr_out, 32'h100 + 32'(4 * k)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld%0d_busy got %b exp 1", k, busy); end
            if (k == 2) set_write(1'b0, R3);
            if (k == 3) begin
                checks++; if (peek_all !== R3) begin errors++; $display("FAIL ld_wb_visible got %h exp %h", peek_all, R3); end
            end
        end
        @(negedge clk);
        checks++; if ({busy, bram_addr_out} !== {1'b1, 32'h10C}) begin errors++; $display("FAIL ld4_state got busy %b addr %h exp 1 10c", busy, bram_addr_out); end
        @(negedge clk);
        checks++; if ({busy, cmd_ready} !== 2'b01) begin errors++; $display("FAIL ld_done_busy_ready got %b exp 01", {busy, cmd_ready}); end
        checks++; if (peek_all !== LDX) begin errors++; $display("FAIL ld_commit got %h exp %h", peek_all, LDX); end
        checks++; if (bram_addr_out !== 32'h10C) begin errors++; $display("FAIL ld_addr_hold got %h exp 10c", bram_addr_out); end
    endtask

    task automatic test_arbitration;
        peek_mode = 1'b0;
        @(negedge clk);
        set_write(1'b0, RA);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_mode = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL arb_ready_low got %b exp 0", cmd_ready); end
        @(negedge clk);
        matrix_write_en = 1'b0;
        #1;
        checks++; if ({mv_level, cmd_ready} !== {3'd0, 1'b1}) begin errors++; $display("FAIL arb_stall got lvl %0d rdy %b exp 0 1", mv_level, cmd_ready); end
        checks++; if (peek_all !== RA) begin errors++; $display("FAIL arb_written got %h exp %h", peek_all, RA); end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
        checks++; if (mv_level !== 3'd1) begin errors++; $display("FAIL arb_push_level got %0d exp 1", mv_level); end
        checks++; if (peek_all !== RA) begin errors++; $display("FAIL arb_push_dup got %h exp %h", peek_all, RA); end
    endtask

    task automatic test_reset_mid_load;
        @(negedge clk);
        bram_addr_in = 32'h200; cmd_valid = 1'b1; cmd_op = 3'd4; cmd_mode = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, bram_addr_out} !== {1'b1, 32'h208}) begin errors++; $display("FAIL rml_ld2 got busy %b addr %h exp 1 208", busy, bram_addr_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, bram_addr_out} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rml_busy_addr got busy %b addr %h exp 0 0", busy, bram_addr_out); end
        checks++; if (mv_level !== 3'd0) begin errors++; $display("FAIL rml_mv_level got %0d exp 0", mv_level); end
        peek_mode = 1'b0; #1;
        checks++; if (peek_all !== IDENT) begin errors++; $display("FAIL rml_mv_ident got %h exp %h", peek_all, IDENT); end
        peek_mode = 1'b1; #1;
        checks++; if (peek_all !== IDENT) begin errors++; $display("FAIL rml_pj_ident got %h exp %h", peek_all, IDENT); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, peek_all} !== {1'b0, IDENT}) begin errors++; $display("FAIL rml_no_late_commit got busy %b peek %h", busy, peek_all); end
    endtask

    initial begin
        test_reset();
        test_write_push_pop();
        test_mv_saturation();
        test_pj_saturation();
        test_load_bram();
        test_arbitration();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_stack.md
Name: matrix_stack

Overview:
- Holds the GL modelview (mode 0) and projection (mode 1) matrix stacks.
- Serves the top-of-stack to the matrix multiplier through four 128-bit peek rows, combinationally.
- Accepts the multiplier's 4-row write-back into the top of the selected stack.
- Executes stack commands: push, pop, load-identity, and a 4-row load of a matrix from BRAM.

Parameters:
- MV_DEPTH, 8, number of modelview stack entries (power of 2, at least 2).
- PJ_DEPTH, 2, number of projection stack entries (power of 2, at least 2).
- ONE, 32'h3F800000, bit pattern written on identity diagonals; all other elements are 0.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 LOAD_IDENTITY, 4 LOAD_BRAM, 5 CLR_ERR, 6-7 treated as NOP.
- cmd_mode  in  1  stack targeted by the command: 0 modelview, 1 projection.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- busy  out  1  high while LOAD_BRAM is in progress.
- peek_mode  in  1  selects which stack's top drives the peek rows.
- matrix_peek_0..3  out  128 each  top-of-stack rows 0..3; element 0 in bits [127:96]; combinational from peek_mode.
- matrix_mode_in  in  1  stack targeted by the write-back.
- matrix_write_en  in  1  one-cycle write-back strobe.
- matrix_write_in_0..3  in  128 each  write-back rows 0..3.
- bram_addr_in  in  32  base BRAM address of the matrix for LOAD_BRAM.
- bram_addr_out  out  32  BRAM read address.
- bram_read_in_0..3  in  32 each  BRAM data, valid 1 cycle after the address is presented.
- mv_level  out  log2(MV_DEPTH)  modelview stack pointer.
- pj_level  out  log2(PJ_DEPTH)  projection stack pointer.
- overflow  out  1  sticky error flag.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (async, any time, including mid-LOAD):
  - Both pointers 0; entry 0 of both stacks = identity; other entries unchanged.
  - FSM returns to IDLE; busy 0; bram_addr_out 0; overflow and underflow 0.
- cmd_ready = !busy && !matrix_write_en. Write-back therefore always wins over a command in the same cycle; the command stalls.
- Write-back: when matrix_write_en is high, rows 0..3 overwrite entry[ptr] of the stack selected by matrix_mode_in on that edge. The write is accepted even while busy.
- Peek: a write, push, pop or load is visible on matrix_peek_* the cycle after its commit edge.
- PUSH:
  - If ptr < DEPTH-1: entry[ptr+1] = entry[ptr], then ptr++ (top is duplicated).
  - Else: ignored and overflow is set.
- POP:
  - If ptr > 0: ptr--; the popped contents are left stale.
  - Else: ignored and underflow is set.
- LOAD_IDENTITY: entry[ptr] = identity; 1 cycle.
- CLR_ERR: clears overflow and underflow; 1 cycle. Flags otherwise hold until rst.
- LOAD_BRAM FSM:
  - States IDLE -> LD0 -> LD1 -> LD2 -> LD3 -> LD4 -> IDLE.
  - Accept edge: latch base = bram_addr_in and the target mode; go to LD0 with busy=1.
  - In LDk (k = 0..3): bram_addr_out = base + 4k.
  - In LD(k+1): capture row k = {bram_read_in_0, in_1, in_2, in_3}.
  - At the LD4 edge: row 3 is captured and all 4 rows commit to entry[ptr] of the latched stack; busy drops the following cycle.
  - Total: 6 cycles from accept to the next command being accepted.
  - bram_addr_out holds its last value while IDLE.
- Write-back during LOAD_BRAM to the same stack: applied immediately, then overwritten by the LD4 commit.
- Pointer arithmetic never wraps; saturation is governed by the overflow and underflow rules above.
- Only one command per accepted cycle; commands do not affect the non-selected stack.

Test Plan:
- Reset:
  - Stimulus: release rst, then peek_mode=0 and peek_mode=1.
  - Response: matrix_peek_0 = {ONE,0,0,0} and matrix_peek_3 = {0,0,0,ONE}; mv_level = pj_level = 0; overflow = underflow = 0.
- Write/push/pop:
  - Stimulus: write rows 128'h1..4 to mode 0, PUSH mode 0, write rows 128'h5..8, POP.
  - Response: mv_level goes 1 then 0; after POP, peek (mode 0) = 1..4.
- Projection saturation:
  - Stimulus: 2 PUSHes to mode 1 with PJ_DEPTH=2.
  - Response: pj_level = 1 and overflow = 1.
  - Stimulus: then 2 POPs.
  - Response: pj_level = 0 and underflow = 1.
  - Stimulus: then CLR_ERR.
  - Response: both flags 0.
- LOAD_BRAM:
  - Stimulus: bram_addr_in = 32'h100; BRAM model returns word = address.
  - Response: bram_addr_out = 100, 104, 108, 10C in LD0-LD3; busy high for 5 cycles; then peek row 0 = {100,100,100,100} and row 3 = {10C,10C,10C,10C}.
- Arbitration:
  - Stimulus: cmd_valid with PUSH in the same cycle as matrix_write_en.
  - Response: cmd_ready = 0; the push completes next cycle and duplicates the written matrix.
- Reset mid-load:
  - Stimulus: assert rst during LD2.
  - Response: busy = 0 immediately and peek = identity.
